// File: rtl/slow_clk_meter_if.sv
// Measurement result channel for slow_clk_meter: valid/ready handshake
// carrying the measured period and high time in fast-clock cycles.
interface slow_clk_meter_if #(
    parameter int unsigned CNT_W = 28
) ();
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;

    modport master (
        output meas_valid,
        output period,
        output high_time,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  period,
        input  high_time,
        output meas_ready
    );
endinterface

// File: rtl/slow_clk_meter.sv
// Period / high-time meter for an asynchronous slow clock, sampled in the
// fast clk domain. Results leave on a valid/ready channel; locked, timeout
// and overrun flag the input's health.
// Optional feature macro: DUTY_CHECK_EN adds a registered duty_ok output
// (|2*high_time - period| <= 1), updated together with period.
module slow_clk_meter #(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned TIMEOUT     = 200000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_clk_in,
    slow_clk_meter_if.master meas,
    output logic             locked,
    output logic             timeout,
`ifdef DUTY_CHECK_EN
    output logic             duty_ok,
`endif
    output logic             overrun
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StMeasHigh,
        StMeasLow
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hi_hold_q, hi_hold_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;
    logic                   overrun_q, overrun_d;

    logic                   sync_bit;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   new_meas;
    logic                   to_fire;

`ifdef DUTY_CHECK_EN
    logic                   duty_ok_q, duty_ok_d;
    logic [CNT_W:0]         two_hi;
    logic [CNT_W:0]         per_ext;
    logic [CNT_W:0]         duty_diff;
    logic                   duty_hit;
`endif

    // Synchroniser shift and edge history feeding the edge detector.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], slow_clk_in};
        hist_d   = sync_q[SYNC_STAGES-1];
        sync_bit = sync_q[SYNC_STAGES-1];
        rise     = sync_bit & ~hist_q;
        fall     = ~sync_bit & hist_q;
        // Saturate so the counter can never run past TIMEOUT and wrap.
        cnt_inc  = (cnt_q == TimeoutCnt) ? cnt_q : cnt_q + CntOne;
    end

`ifdef DUTY_CHECK_EN
    // Duty check on the result being captured this cycle (cnt_q, hi_hold_q).
    always_comb begin
        two_hi    = {hi_hold_q, 1'b0};
        per_ext   = {1'b0, cnt_q};
        duty_diff = (two_hi >= per_ext) ? (two_hi - per_ext) : (per_ext - two_hi);
        duty_hit  = (duty_diff <= (CNT_W+1)'(1));
    end
`endif

    // Measurement FSM, timeout and result handshake next-state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_hold_d    = hi_hold_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = meas_valid_q;
        locked_d     = locked_q;
        timeout_d    = 1'b0;
        overrun_d    = 1'b0;
        new_meas     = 1'b0;
        to_fire      = 1'b0;
`ifdef DUTY_CHECK_EN
        duty_ok_d    = duty_ok_q;
`endif

        case (state_q)
            StIdle: begin
                // First rise only arms the meter; falls are ignored here.
                if (rise) begin
                    cnt_d   = CntOne;
                    state_d = StMeasHigh;
                end
            end
            StMeasHigh: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    hi_hold_d = cnt_q;
                    state_d   = StMeasLow;
                end else if (cnt_q == TimeoutCnt) begin
                    to_fire = 1'b1;
                end
            end
            StMeasLow: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    new_meas = 1'b1;
                    cnt_d    = CntOne;
                    state_d  = StMeasHigh;
                end else if (cnt_q == TimeoutCnt) begin
                    to_fire = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (to_fire) begin
            // Result registers and meas_valid are deliberately left alone.
            state_d   = StIdle;
            cnt_d     = cnt_q;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
`ifdef DUTY_CHECK_EN
            duty_ok_d = 1'b0;
`endif
        end

        if (new_meas) begin
            period_d     = cnt_q;
            high_time_d  = hi_hold_q;
            meas_valid_d = 1'b1;
            locked_d     = 1'b1;
            overrun_d    = meas_valid_q & ~meas.meas_ready;
`ifdef DUTY_CHECK_EN
            duty_ok_d    = duty_hit;
`endif
        end else if (meas_valid_q && meas.meas_ready) begin
            meas_valid_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            hist_q       <= 1'b0;
            state_q      <= StIdle;
            cnt_q        <= '0;
            hi_hold_q    <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef DUTY_CHECK_EN
            duty_ok_q    <= 1'b0;
`endif
        end else begin
            sync_q       <= sync_d;
            hist_q       <= hist_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_hold_q    <= hi_hold_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
`ifdef DUTY_CHECK_EN
            duty_ok_q    <= duty_ok_d;
`endif
        end
    end

    assign meas.meas_valid = meas_valid_q;
    assign meas.period     = period_q;
    assign meas.high_time  = high_time_q;
    assign locked          = locked_q;
    assign timeout         = timeout_q;
    assign overrun         = overrun_q;
`ifdef DUTY_CHECK_EN
    assign duty_ok         = duty_ok_q;
`endif

endmodule

// File: tb/tb_slow_clk_meter.sv
// Bench for slow_clk_meter: table of square-wave scenarios with fixed
// expected results, hand-written timeout / reset sequences, and random
// waveforms checked every cycle against a timestamp-based reference model.
module tb_slow_clk_meter;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned TO      = 64;
    localparam int unsigned SYNC    = 2;

    logic clk;
    logic rst_n;
    logic slow_clk_in;
    logic locked;
    logic timeout;
    logic overrun;
`ifdef DUTY_CHECK_EN
    logic duty_ok;
`endif

    slow_clk_meter_if #(.CNT_W(CNT_W)) meas_if ();

    slow_clk_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TO),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .slow_clk_in(slow_clk_in),
        .meas       (meas_if),
        .locked     (locked),
        .timeout    (timeout),
`ifdef DUTY_CHECK_EN
        .duty_ok    (duty_ok),
`endif
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: edges are timestamps; results are differences.
    bit pin_q[$];
    int m_t, m_r0, m_hi, m_per, m_ht;
    bit m_armed, m_hi_phase, m_mv, m_locked, m_to, m_ov, m_duty;

    // Observation counters for hand-written sequences.
    int n_step;
    int to_cnt, to_step, ov_cnt, mv_cnt;

    typedef struct {
        int hi;
        int lo;
        int nper;
        bit rdy;
        int exp_per;
        int exp_ht;
        bit exp_duty;
        int exp_ov;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pin_q.delete();
        for (int i = 0; i < int'(SYNC) + 1; i++) pin_q.push_back(1'b0);
        m_t = 0; m_r0 = 0; m_hi = 0; m_per = 0; m_ht = 0;
        m_armed = 0; m_hi_phase = 0; m_mv = 0; m_locked = 0;
        m_to = 0; m_ov = 0; m_duty = 0;
    endtask

    // One clk cycle: drive at negedge, model at posedge, compare at negedge.
    task automatic step(input bit v, input bit rdy);
        bit cur, prev, rise, fall, accept, newm, tofire;
        int el, d;
        slow_clk_in          = v;
        meas_if.meas_ready   = rdy;
        pin_q.push_back(v);
        if (pin_q.size() > int'(SYNC) + 2) void'(pin_q.pop_front());
        @(posedge clk);
        n_step++;
        m_t++;
        // An input change is seen SYNC cycles after it is sampled.
        prev   = pin_q[0];
        cur    = pin_q[1];
        rise   = cur & ~prev;
        fall   = ~cur & prev;
        el     = m_t - m_r0;
        accept = m_mv && rdy;
        newm   = 0;
        tofire = 0;
        m_to   = 0;
        m_ov   = 0;
        if (!m_armed) begin
            if (rise) begin
                m_armed = 1; m_hi_phase = 1; m_r0 = m_t;
            end
        end else if (m_hi_phase) begin
            if (fall) begin
                m_hi = (el > int'(TO)) ? int'(TO) : el;
                m_hi_phase = 0;
            end else if (el >= int'(TO)) tofire = 1;
        end else begin
            if (rise) begin
                newm = 1;
                m_per = (el > int'(TO)) ? int'(TO) : el;
                m_ht = m_hi;
                m_r0 = m_t;
                m_hi_phase = 1;
            end else if (el >= int'(TO)) tofire = 1;
        end
        if (tofire) begin
            m_armed = 0; m_locked = 0; m_to = 1; m_duty = 0;
        end
        if (newm) begin
            m_ov = m_mv && !rdy;
            m_mv = 1;
            m_locked = 1;
            d = 2 * m_ht - m_per;
            if (d < 0) d = -d;
            m_duty = (d <= 1);
        end else if (accept) begin
            m_mv = 0;
        end
        @(negedge clk);
        chk("meas_valid", 32'(meas_if.meas_valid), 32'(m_mv));
        chk("period", 32'(meas_if.period), 32'(m_per));
        chk("high_time", 32'(meas_if.high_time), 32'(m_ht));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("overrun", 32'(overrun), 32'(m_ov));
`ifdef DUTY_CHECK_EN
        chk("duty_ok", 32'(duty_ok), 32'(m_duty));
`endif
        if (timeout === 1'b1) begin
            to_cnt++;
            to_step = n_step;
        end
        if (overrun === 1'b1) ov_cnt++;
        if (meas_if.meas_valid === 1'b1) mv_cnt++;
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_meas_valid", 32'(meas_if.meas_valid), 32'd0);
        chk("rst_period", 32'(meas_if.period), 32'd0);
        chk("rst_high_time", 32'(meas_if.high_time), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
`ifdef DUTY_CHECK_EN
        chk("rst_duty_ok", 32'(duty_ok), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        to_cnt = 0; to_step = 0; ov_cnt = 0; mv_cnt = 0;
    endtask

    initial begin
        int k, hi, lo;
        bit rdy;

        vecs[0] = '{5, 5, 6, 1'b1, 10, 5, 1'b1, 0};
        vecs[1] = '{5, 5, 3, 1'b0, 10, 5, 1'b1, 2};
        vecs[2] = '{7, 13, 3, 1'b1, 20, 7, 1'b0, 0};
        vecs[3] = '{10, 10, 3, 1'b1, 20, 10, 1'b1, 0};
        vecs[4] = '{1, 15, 4, 1'b1, 16, 1, 1'b0, 0};
        vecs[5] = '{1, 15, 3, 1'b0, 16, 1, 1'b0, 2};
        vecs[6] = '{3, 4, 3, 1'b1, 7, 3, 1'b1, 0};

        rst_n              = 1'b1;
        slow_clk_in        = 1'b0;
        meas_if.meas_ready = 1'b0;
        n_step             = 0;
        model_reset();

        // Table-driven square-wave scenarios.
        for (int v = 0; v < 7; v++) begin
            slow_clk_in = 1'b0;
            do_reset();
            for (int p = 0; p <= vecs[v].nper; p++) begin
                repeat (vecs[v].hi) step(1'b1, vecs[v].rdy);
                repeat (vecs[v].lo) step(1'b0, vecs[v].rdy);
            end
            repeat (6) step(1'b0, vecs[v].rdy);
            chk("tbl_period", 32'(meas_if.period), 32'(vecs[v].exp_per));
            chk("tbl_high_time", 32'(meas_if.high_time), 32'(vecs[v].exp_ht));
            chk("tbl_meas_valid", 32'(meas_if.meas_valid), 32'(!vecs[v].rdy));
            chk("tbl_overruns", 32'(ov_cnt), 32'(vecs[v].exp_ov));
            chk("tbl_locked", 32'(locked), 32'd1);
`ifdef DUTY_CHECK_EN
            chk("tbl_duty_ok", 32'(duty_ok), 32'(vecs[v].exp_duty));
`endif
            if (!vecs[v].rdy) begin
                step(1'b0, 1'b1);
                chk("ready_clears_valid", 32'(meas_if.meas_valid), 32'd0);
            end
        end

        // Timeout: lock, then stall the input high.
        slow_clk_in = 1'b0;
        do_reset();
        repeat (2) begin
            repeat (5) step(1'b1, 1'b1);
            repeat (5) step(1'b0, 1'b1);
        end
        step(1'b1, 1'b1);
        k = n_step;
        repeat (3) step(1'b1, 1'b1);
        chk("to_locked_before", 32'(locked), 32'd1);
        repeat (100) step(1'b1, 1'b1);
        chk("to_pulse_count", 32'(to_cnt), 32'd1);
        chk("to_delay", 32'(to_step - k), 32'(SYNC + TO));
        chk("to_locked_after", 32'(locked), 32'd0);
        chk("to_period_kept", 32'(meas_if.period), 32'd10);
        // Restart: the first rise only arms, the second one measures.
        repeat (5) step(1'b0, 1'b1);
        mv_cnt = 0;
        repeat (5) step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b1);
        chk("restart_no_early_meas", 32'(mv_cnt), 32'd0);
        repeat (4) step(1'b1, 1'b1);
        chk("restart_one_meas", 32'(mv_cnt), 32'd1);
        chk("restart_locked", 32'(locked), 32'd1);

        // Reset in the middle of the low phase.
        slow_clk_in = 1'b0;
        do_reset();
        repeat (3) begin
            repeat (5) step(1'b1, 1'b0);
            repeat (5) step(1'b0, 1'b0);
        end
        repeat (5) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        chk("mid_valid_before_rst", 32'(meas_if.meas_valid), 32'd1);
        do_reset();
        repeat (5) step(1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        chk("post_rst_no_stale", 32'(mv_cnt), 32'd0);
        repeat (4) step(1'b1, 1'b0);
        chk("post_rst_first_meas", 32'(meas_if.period), 32'd10);

        // Random waveforms, including stalls long enough to time out.
        slow_clk_in = 1'b0;
        do_reset();
        for (int ph = 0; ph < 80; ph++) begin
            hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(70, 90))
                                             : int'($urandom_range(1, 40));
            lo = int'($urandom_range(1, 90));
            for (int c = 0; c < hi; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                step(1'b1, rdy);
            end
            for (int c = 0; c < lo; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                step(1'b0, rdy);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
